hilo_div_unit: RTL

//  Multi-cycle iterative divider for the MIPS pipeline EX stage. It implements DIV and DIVU.
//  It is the write side of the Hi/Lo interface: it produces quotient -> Lo and remainder -> Hi.
//  The ALU then reads these through MFHI/MFLO.

---
 rtl/hilo_div_unit_if.sv | 26 ++
 rtl/hilo_div_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit_if.sv
// Hi/Lo divider request/response bundle.
// The pipeline (master) issues start with operands and stalls on busy;
// the divider (slave) returns quotient on lo, remainder on hi with a done pulse.
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU; writes quotient to Lo and
// remainder to Hi. One quotient bit per cycle, WIDTH+2 cycles per operation
// (accept, WIDTH steps, result fix-up).
// Build option: define HILO_DIV_SIGNED_EN to honour is_signed (DIV). When it is
// undefined every op is DIVU and no negation hardware is built; handshake and
// timing do not change.
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    hilo_div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    // Partial remainder. Before each step it is strictly below |B|, so WIDTH
    // bits hold it; the WIDTH+1-bit value only exists after the shift.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Operand magnitudes and sign fix-up terms
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_res, r_res;

`ifdef HILO_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg, b_neg;

    // Signed magnitudes: negate only when the op is signed and the MSB is set.
    always_comb begin
        a_neg  = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg  = bus.is_signed & bus.divisor[WIDTH-1];
        a_mag  = a_neg ? -bus.dividend : bus.dividend;
        b_mag  = b_neg ? -bus.divisor  : bus.divisor;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == IDLE && bus.start) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
        end
        // Remainder follows the dividend sign; MIN_INT/-1 wraps to MIN_INT.
        q_res = qneg_q ? -quo_q : quo_q;
        r_res = rneg_q ? -rem_q : rem_q;
    end

    // Sign flags live only as long as the operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    // Unsigned-only build: operands are already magnitudes.
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        q_res = quo_q;
        r_res = rem_q;
    end
`endif

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             take;

    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        take    = (rem_sh >= {1'b0, bmag_q});
        // When take is set the true difference is below |B|, so the
        // WIDTH-bit wrap-around subtraction is exact.
        rem_sub = rem_sh[WIDTH-1:0] - bmag_q;
    end

    // Next-state and datapath control for IDLE -> CALC -> FIN -> IDLE
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bmag_d  = bmag_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    quo_d   = a_mag;
                    rem_d   = '0;
                    bmag_d  = b_mag;
                    count_d = CW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                quo_d = {quo_q[WIDTH-2:0], take};
                rem_d = take ? rem_sub : rem_sh[WIDTH-1:0];
                if (count_q == '0) begin
                    state_d = FIN;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            FIN: begin
                lo_d    = q_res;
                hi_d    = r_res;
                dbz_d   = (bmag_q == '0);
                done_d  = 1'b1;
                // Dropping busy with done lets the next start land back-to-back.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM and result registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            bmag_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            bmag_q  <= bmag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
